// File: rtl/fir_pkg.sv
// Shared types and constants for the four-tap FIR core and its MAC unit.
package fir_pkg;

  localparam int NUM_TAPS  = 4;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 15;
  localparam int ACC_W     = 34;

  // Bit k set means tap k is subtracted: y = t0c0 - t1c1 + t2c2 - t3c3
  localparam logic [NUM_TAPS-1:0] TAP_SUB = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    MAC   = 2'd3
  } fir_state_t;

  // Drop the Q1.15 fraction and clamp to the unsigned output range; returns {err, value}
  function automatic logic [DATA_W:0] clamp_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    logic [DATA_W:0] res;
    r = acc >>> FRAC_BITS;
    if (r[ACC_W-1]) begin
      res = {1'b1, {DATA_W{1'b0}}};
    end else if (|r[ACC_W-2:DATA_W]) begin
      res = {1'b1, {DATA_W{1'b1}}};
    end else begin
      res = {1'b0, r[DATA_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared 16x16 unsigned multiplier with signed add/sub into a clearable accumulator.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    subtract,
  input  logic [DATA_W-1:0]       sample,
  input  logic [DATA_W-1:0]       coeff,
  output logic signed [ACC_W-1:0] sum
);

  logic [2*DATA_W-1:0]     product_s;
  logic signed [ACC_W-1:0] product_ext_s;
  logic signed [ACC_W-1:0] acc_r;

  // Product is unsigned, zero-extended so the sign comes only from the tap pattern
  always_comb begin
    product_s     = {{DATA_W{1'b0}}, sample} * {{DATA_W{1'b0}}, coeff};
    product_ext_s = signed'({{(ACC_W-2*DATA_W){1'b0}}, product_s});
    if (subtract) begin
      sum = acc_r - product_ext_s;
    end else begin
      sum = acc_r + product_ext_s;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clear) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (enable) begin
      acc_r <= sum;
    end
  end

endmodule

// File: rtl/fir_filter_core.sv
// Four-tap FIR controller: coefficient fetch, tap shift register and one-tap-per-cycle MAC sequencing.
module fir_filter_core
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              data_ready,
  input  logic              new_coefficient_set,
  input  logic [DATA_W-1:0] fir_coefficient,
  output logic [1:0]        coefficient_num,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err
);

  fir_state_t              state_r;
  logic [1:0]              tap_idx_r;
  logic [DATA_W-1:0]       taps_r   [NUM_TAPS];
  logic [DATA_W-1:0]       coeffs_r [NUM_TAPS];
  logic [DATA_W-1:0]       cur_tap_s;
  logic [DATA_W-1:0]       cur_coeff_s;
  logic                    subtract_s;
  logic                    mac_clear_s;
  logic                    mac_en_s;
  logic signed [ACC_W-1:0] sum_s;

  // Operand selection for the shared multiplier
  always_comb begin
    cur_tap_s   = taps_r[tap_idx_r];
    cur_coeff_s = coeffs_r[tap_idx_r];
    subtract_s  = TAP_SUB[tap_idx_r];
    mac_clear_s = (state_r == IDLE) && data_ready;
    mac_en_s    = (state_r == MAC);
  end

  fir_mac_unit u_mac (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (mac_clear_s),
    .enable   (mac_en_s),
    .subtract (subtract_s),
    .sample   (cur_tap_s),
    .coeff    (cur_coeff_s),
    .sum      (sum_s)
  );

  // Control FSM with registered outputs, tap shift register and coefficient capture
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r         <= IDLE;
      tap_idx_r       <= 2'd0;
      coefficient_num <= 2'd0;
      modwait         <= 1'b0;
      fir_out         <= {DATA_W{1'b0}};
      err             <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps_r[i]   <= {DATA_W{1'b0}};
        coeffs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (data_ready) begin
            for (int i = NUM_TAPS-1; i > 0; i--) begin
              taps_r[i] <= taps_r[i-1];
            end
            taps_r[0] <= sample_data;
            tap_idx_r <= 2'd0;
            state_r   <= SHIFT;
            modwait   <= 1'b1;
          end else if (new_coefficient_set) begin
            state_r <= LOAD;
            modwait <= 1'b1;
          end else begin
            modwait <= 1'b0;
          end
        end
        LOAD: begin
          coeffs_r[coefficient_num] <= fir_coefficient;
          if (coefficient_num == 2'd3) begin
            coefficient_num <= 2'd0;
            state_r         <= IDLE;
            modwait         <= 1'b0;
          end else begin
            coefficient_num <= coefficient_num + 2'd1;
          end
        end
        SHIFT: begin
          state_r <= MAC;
        end
        MAC: begin
          if (tap_idx_r == 2'd3) begin
            {err, fir_out} <= clamp_result(sum_s);
            // A reload queued behind a sample starts at once so modwait never dips
            if (new_coefficient_set) begin
              state_r <= LOAD;
            end else begin
              state_r <= IDLE;
              modwait <= 1'b0;
            end
          end else begin
            tap_idx_r <= tap_idx_r + 2'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          modwait <= 1'b0;
        end
      endcase
    end
  end

endmodule
